// File: rtl/bo_pkg.sv
// bo_pkg: shared encodings for the operative block (BO) of the 4-bit-state
// control FSM. The datapath, the FSM and the testbench import it so that
// every side decodes the M0/M1/M2 selects the same way.
//
// Contents:
//   OPA_*  operand-A select codes (M0)
//   OPB_*  operand-B select codes (M1)
//   ALU_*  ALU operation codes  (M2)
package bo_pkg;

    localparam logic [1:0] OPA_S = 2'b00;
    localparam logic [1:0] OPA_X = 2'b01;
    localparam logic [1:0] OPA_H = 2'b10;
    localparam logic [1:0] OPA_B = 2'b11;

    localparam logic [1:0] OPB_X   = 2'b00;
    localparam logic [1:0] OPB_ONE = 2'b01;
    localparam logic [1:0] OPB_H   = 2'b10;
    localparam logic [1:0] OPB_B   = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_CLR  = 2'b11;

endpackage

// File: rtl/bo_alu.sv
// bo_alu: combinational ALU shared by the H and S registers.
//
// Ports:
//   i_a       operand A
//   i_b       operand B
//   i_op      operation (ALU_ADD / ALU_SUB / ALU_PASS / ALU_CLR)
//   o_result  result, modulo 2^WIDTH
//   o_carry   carry-out for add, borrow (i_a < i_b) for sub, 0 otherwise
module bo_alu
    import bo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    // One extra bit holds carry-out for add; for sub the extra bit goes to 1
    // exactly when the unsigned subtraction borrows.
    logic [WIDTH:0] w_ext;

    always_comb begin
        w_ext    = '0;
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            ALU_ADD: begin
                w_ext    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_ext[WIDTH-1:0];
                o_carry  = w_ext[WIDTH];
            end
            ALU_SUB: begin
                w_ext    = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_ext[WIDTH-1:0];
                o_carry  = w_ext[WIDTH];
            end
            ALU_PASS: begin
                o_result = i_a;
            end
            default: begin
                o_result = '0;
            end
        endcase
    end

endmodule

// File: rtl/bo_datapath.sv
// bo_datapath: operative block for the control FSM. Holds X (operand),
// H (counter/accumulator) and S (result) around one shared ALU. All
// sequencing comes from the FSM strobes; this block has no state machine.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   H               FSM busy flag, delayed one cycle into PRONTO
//   LX, LH, LS      load strobes for X (from A_IN), Hreg and S (from ALU)
//   M0, M1, M2      operand-A select, operand-B select, ALU operation
//   A_IN, B_IN      external operands
//   ZERO            Hreg == 0, decoded straight from the register
//   RESULT          S register
//   PRONTO          registered ready flag (~H delayed one cycle)
//   OVF             sticky overflow/borrow flag, cleared by LX
module bo_datapath
    import bo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             H,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    output logic             ZERO,
    output logic [WIDTH-1:0] RESULT,
    output logic             PRONTO,
    output logic             OVF
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_s;
    logic             r_pronto;
    logic             r_ovf;

    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_carry;

    always_comb begin
        w_opa = '0;
        case (M0)
            OPA_S:   w_opa = r_s;
            OPA_X:   w_opa = r_x;
            OPA_H:   w_opa = r_h;
            default: w_opa = B_IN;
        endcase
    end

    always_comb begin
        w_opb = '0;
        case (M1)
            OPB_X:   w_opb = r_x;
            OPB_ONE: w_opb = WIDTH'(1);
            OPB_H:   w_opb = r_h;
            default: w_opb = B_IN;
        endcase
    end

    bo_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a      (w_opa),
        .i_b      (w_opb),
        .i_op     (M2),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry)
    );

    // The ALU always sees pre-edge X, so LX alongside LH/LS uses the old X.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_h      <= '0;
            r_s      <= '0;
            r_pronto <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (LX) r_x <= A_IN;
            if (LH) r_h <= w_alu_result;
            if (LS) r_s <= w_alu_result;
            r_pronto <= ~H;
            // A new operation (LX) clears the flag even if this same edge
            // overflows.
            if (LX)
                r_ovf <= 1'b0;
            else if ((LH | LS) && w_alu_carry)
                r_ovf <= 1'b1;
        end
    end

    assign ZERO   = (r_h == '0);
    assign RESULT = r_s;
    assign PRONTO = r_pronto;
    assign OVF    = r_ovf;

endmodule

// File: tb/tb_bo_datapath.sv
// tb_bo_datapath: directed self-checking bench for bo_datapath (WIDTH=8).
module tb_bo_datapath;
    import bo_pkg::*;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             H, LX, LH, LS;
    logic [1:0]       M0, M1, M2;
    logic [WIDTH-1:0] A_IN, B_IN;
    logic             ZERO, PRONTO, OVF;
    logic [WIDTH-1:0] RESULT;

    int checks   = 0;
    int failures = 0;

    bo_datapath #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .H      (H),
        .LX     (LX),
        .LH     (LH),
        .LS     (LS),
        .M0     (M0),
        .M1     (M1),
        .M2     (M2),
        .A_IN   (A_IN),
        .B_IN   (B_IN),
        .ZERO   (ZERO),
        .RESULT (RESULT),
        .PRONTO (PRONTO),
        .OVF    (OVF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of strobes, clock it, and leave outputs settled #1 after the edge.
    task automatic cyc(input logic lx, input logic lh, input logic ls,
                       input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        LX = lx; LH = lh; LS = ls;
        M0 = m0; M1 = m1; M2 = m2;
        A_IN = a; B_IN = b;
        @(posedge clk);
        #1;
        LX = 1'b0; LH = 1'b0; LS = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, 8'd0, 8'd0);
    endtask

    // X=x, Hreg=n, S=0
    task automatic mul_setup(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] n);
        cyc(1'b1, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, x, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, OPA_B, OPB_X, ALU_PASS, 8'd0, n);
        cyc(1'b0, 1'b0, 1'b1, OPA_S, OPB_X, ALU_CLR, 8'd0, 8'd0);
    endtask

    task automatic mul_iter();
        cyc(1'b0, 1'b0, 1'b1, OPA_S, OPB_X,   ALU_ADD, 8'd0, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, OPA_H, OPB_ONE, ALU_SUB, 8'd0, 8'd0);
    endtask

    task automatic mul_run(input string tag, input int exp_iters);
        int iters = 0;
        while (!ZERO && iters < 20) begin
            mul_iter();
            iters++;
        end
        check({tag, "_iters"}, iters, exp_iters);
    endtask

    initial begin
        rst = 1'b1; H = 1'b1;
        LX = 1'b1; LH = 1'b1; LS = 1'b1;
        M0 = OPA_B; M1 = OPB_B; M2 = ALU_ADD;
        A_IN = 8'hFF; B_IN = 8'hFF;

        // Reset with every strobe active (B+B overflows, must be ignored)
        repeat (2) @(posedge clk);
        #1;
        check("rst_zero",   ZERO,   1);
        check("rst_result", RESULT, 0);
        check("rst_pronto", PRONTO, 0);
        check("rst_ovf",    OVF,    0);
        rst = 1'b0; H = 1'b0;
        LX = 1'b0; LH = 1'b0; LS = 1'b0;
        // X cleared by reset: pass X into S
        cyc(1'b0, 1'b0, 1'b1, OPA_X, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("rst_x", RESULT, 0);

        // Load / pass / clear
        cyc(1'b1, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, 8'd5, 8'd0);
        check("ld_result_hold", RESULT, 0);
        cyc(1'b0, 1'b0, 1'b1, OPA_X, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("ld_pass_x", RESULT, 5);
        cyc(1'b0, 1'b1, 1'b0, OPA_X, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("ld_h_nonzero", ZERO, 0);
        cyc(1'b0, 1'b1, 1'b0, OPA_X, OPB_X, ALU_CLR, 8'd0, 8'd0);
        check("ld_h_clear", ZERO, 1);
        check("ld_s_hold", RESULT, 5);

        // Multiply 3x4
        mul_setup(8'd3, 8'd4);
        check("mul_zero_start", ZERO, 0);
        check("mul_s_start", RESULT, 0);
        mul_run("mul", 4);
        check("mul_result", RESULT, 12);
        check("mul_zero",   ZERO,   1);
        check("mul_ovf",    OVF,    0);

        // Overflow: 200 + 100 = 300 -> 44
        cyc(1'b0, 1'b0, 1'b1, OPA_B, OPB_X, ALU_PASS, 8'd0, 8'd200);
        cyc(1'b1, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, 8'd100, 8'd0);
        check("ovf_pre", OVF, 0);
        cyc(1'b0, 1'b0, 1'b1, OPA_S, OPB_X, ALU_ADD, 8'd0, 8'd0);
        check("ovf_add_result", RESULT, 44);
        check("ovf_add_flag",   OVF,    1);
        cyc(1'b0, 1'b0, 1'b1, OPA_X, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("ovf_sticky_result", RESULT, 100);
        check("ovf_sticky", OVF, 1);
        cyc(1'b0, 1'b1, 1'b0, OPA_X, OPB_ONE, ALU_ADD, 8'd0, 8'd0);
        check("ovf_sticky2", OVF, 1);
        cyc(1'b1, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, 8'd5, 8'd0);
        check("ovf_lx_clear", OVF, 0);
        // 3 - 5 into Hreg -> 254 with borrow
        cyc(1'b0, 1'b1, 1'b0, OPA_B, OPB_X, ALU_PASS, 8'd0, 8'd3);
        check("sub_no_borrow_yet", OVF, 0);
        cyc(1'b0, 1'b1, 1'b0, OPA_H, OPB_X, ALU_SUB, 8'd0, 8'd0);
        check("sub_borrow", OVF, 1);
        check("sub_zero", ZERO, 0);
        cyc(1'b0, 1'b0, 1'b1, OPA_H, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("sub_h_value", RESULT, 254);
        // Equal operands: no borrow, result 0
        cyc(1'b1, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, 8'd254, 8'd0);
        cyc(1'b0, 1'b1, 1'b0, OPA_H, OPB_X, ALU_SUB, 8'd0, 8'd0);
        check("sub_eq_zero", ZERO, 1);
        check("sub_eq_ovf",  OVF,  0);

        // Simultaneous LX + LS: ALU sees old X
        cyc(1'b1, 1'b0, 1'b0, OPA_S, OPB_X, ALU_PASS, 8'd7, 8'd0);
        cyc(1'b1, 1'b0, 1'b1, OPA_X, OPB_X, ALU_PASS, 8'd9, 8'd0);
        check("sim_old_x", RESULT, 7);
        cyc(1'b0, 1'b0, 1'b1, OPA_X, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("sim_new_x", RESULT, 9);
        // LX with an overflowing LS: 9 + 250 = 259 -> 3, flag cleared
        cyc(1'b1, 1'b0, 1'b1, OPA_S, OPB_B, ALU_ADD, 8'd1, 8'd250);
        check("sim_ovf_result", RESULT, 3);
        check("sim_ovf_clear",  OVF,    0);
        // LH and LS together take the same value
        cyc(1'b0, 1'b1, 1'b1, OPA_B, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("both_zero",   ZERO,   1);
        check("both_result", RESULT, 0);

        // PRONTO follows ~H with one cycle delay
        H = 1'b1;
        idle();
        check("pronto_busy", PRONTO, 0);
        H = 1'b0;
        #1;
        check("pronto_no_early", PRONTO, 0);
        idle();
        check("pronto_ready", PRONTO, 1);
        H = 1'b1;
        idle();
        check("pronto_busy2", PRONTO, 0);
        H = 1'b0;
        idle();

        // Reset mid-multiply, with OVF set beforehand
        cyc(1'b0, 1'b0, 1'b1, OPA_B, OPB_B, ALU_ADD, 8'd0, 8'd200);
        check("mid_ovf_set", OVF, 1);
        mul_setup(8'd3, 8'd4);
        mul_iter();
        mul_iter();
        check("mid_result", RESULT, 6);
        check("mid_zero",   ZERO,   0);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, OPA_S, OPB_X, ALU_ADD, 8'd0, 8'd0);
        rst = 1'b0;
        check("mid_rst_result", RESULT, 0);
        check("mid_rst_zero",   ZERO,   1);
        check("mid_rst_ovf",    OVF,    0);
        check("mid_rst_pronto", PRONTO, 0);
        cyc(1'b0, 1'b0, 1'b1, OPA_X, OPB_X, ALU_PASS, 8'd0, 8'd0);
        check("mid_rst_x", RESULT, 0);
        mul_setup(8'd3, 8'd4);
        mul_run("resume", 4);
        check("resume_result", RESULT, 12);
        check("resume_ovf",    OVF,    0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- Operative block (BO) for the 4-bit-state control FSM. It consumes that FSM's H, LX, LH, LS, M0, M1 and M2 strobes and returns the ZERO status.
- Holds three registers: X (operand), H (counter/accumulator) and S (result). One shared ALU feeds H and S through the FSM-driven operand muxes.
- Provides the registered result, the ready flag and the sticky overflow flag to the surrounding system.

Parameters:
- WIDTH, 8, data width of X, H, S, the ALU and the data ports.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- H  in  1  FSM busy indication (1 = algorithm in progress).
- LX  in  1  load X from A_IN.
- LH  in  1  load H register from ALU result.
- LS  in  1  load S register from ALU result.
- M0  in  2  ALU operand-A select.
- M1  in  2  ALU operand-B select.
- M2  in  2  ALU operation select.
- A_IN  in  WIDTH  external operand captured by LX.
- B_IN  in  WIDTH  external operand reachable through M0/M1.
- ZERO  out  1  1 when H register == 0; combinational from the register only.
- RESULT  out  WIDTH  current S register.
- PRONTO  out  1  registered ready flag.
- OVF  out  1  sticky overflow/borrow flag.

Behaviour:
- Reset (rst=1 at clock edge): X=0, Hreg=0, S=0, PRONTO=0, OVF=0. Hence ZERO=1 and RESULT=0 in the cycle after reset. rst has priority over every load strobe.
- Operand A by M0: 00 S, 01 X, 10 Hreg, 11 B_IN.
- Operand B by M1: 00 X, 01 constant 1, 10 Hreg, 11 B_IN.
- Operation by M2: 00 add A+B, 01 sub A-B, 10 pass A, 11 clear (result 0).
- ALU is purely combinational. Result is modulo 2^WIDTH (wrap-around, no saturation).
- Carry flag: carry-out for add, borrow (A<B unsigned) for sub, 0 for pass and clear.
- Register loads take effect at the clock edge when the strobe is 1; otherwise the register holds:
  - LX: X <= A_IN.
  - LH: Hreg <= ALU result.
  - LS: S <= ALU result.
- LH and LS together: both registers take the same ALU result.
- LX together with LH/LS: the ALU uses the pre-edge X. The new X is visible from the next cycle.
- Load latency is 1 cycle: RESULT and ZERO reflect a load in the cycle after the strobe.
- OVF update, evaluated in this order each edge:
  - Cleared when LX=1 (start of a new operation).
  - Otherwise set when (LH|LS)=1 and the ALU carry flag=1.
  - Otherwise holds.
  - LX together with an overflowing LH/LS: clear wins.
- PRONTO <= ~H every cycle (one-cycle registered delay of the FSM busy flag).
- Undefined select codes do not exist (all 2-bit codes are decoded). Unknown inputs are not masked.
- No internal state machine: sequencing belongs entirely to the FSM. This block must be cycle-exact so the FSM's ZERO sampling is valid the cycle after any LH.

Decomposition:
- Shared package bo_pkg:
  - Operand-A select encodings: OPA_S, OPA_X, OPA_H, OPA_B.
  - Operand-B select encodings: OPB_X, OPB_ONE, OPB_H, OPB_B.
  - ALU op encodings: ALU_ADD, ALU_SUB, ALU_PASS, ALU_CLR.
  - Reused by the FSM and the testbench.
- One sub-module, bo_alu: inputs WIDTH-bit A, B and 2-bit op; outputs WIDTH-bit result and carry; combinational.
- Muxes and registers stay in bo_datapath.

Test Plan:
- Reset: drive rst=1 with all strobes 1 for 2 cycles -> X=Hreg=S=0, ZERO=1, RESULT=0, PRONTO=0, OVF=0.
- Load/clear, WIDTH=8:
  - A_IN=5, LX=1 -> X=5.
  - Then M0=01, M2=10, LS=1 -> RESULT=5 one cycle later.
  - Then M2=11, LH=1 -> ZERO=1.
- Multiply 3x4 by repeated add:
  - Load X=3; set Hreg=4 via M0=11, B_IN=4, M2=10, LH=1.
  - Loop: S<=S+X (M0=00, M1=00, M2=00, LS) and Hreg<=Hreg-1 (M0=10, M1=01, M2=01, LH) until ZERO.
  - Expect RESULT=12, ZERO=1, OVF=0.
- Overflow:
  - S=200, X=100, add with LS -> RESULT=44, OVF=1.
  - OVF stays 1 across later non-overflowing loads.
  - Next LX clears it to 0.
  - Separately, sub 3-5 into Hreg -> Hreg=254, OVF=1.
- Simultaneous events:
  - LX (A_IN=9) in the same cycle as LS with M0=01, M2=10, X=7 -> S=7, X=9.
  - LX together with an overflowing LS -> OVF=0.
- Reset mid-operation and PRONTO:
  - Toggle H 1->0 -> PRONTO follows with exactly one cycle delay.
  - Assert rst during the multiply loop -> all registers 0 at the next edge; the loop resumes cleanly after rst release.
